uart_tx_mmio: RTL



---
 rtl/uart_tx_mmio_pkg.sv | 27 ++
 rtl/uart_tx_mmio_sync_fifo.sv | 47 ++++
 rtl/uart_tx_mmio.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared register offsets, STATUS bit positions and FSM states for the MMIO UART transmitter.
package uart_tx_mmio_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_PCAP  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_PARITY
    } uart_state_e;

    // A zero divisor would stall the baud counter, so it is stored as 1.
    function automatic logic [15:0] div_fix(input logic [15:0] v);
        return (v == '0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational read port; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO on the core data port.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DIV_DEFAULT = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  dmem_writeb,
    input  logic        dmem_read,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        sel,
    output logic        tx
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e   state_q, state_d;
    logic [15:0]   div_q, div_d, baud_q, baud_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          overflow_q, overflow_d, tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif
    logic [1:0]    offset;
    logic          wr_txdata, wr_status, wr_div, pop, busy;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel       = (dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = dmem_addr[3:2];
    assign wr_txdata = sel && (offset == OFF_TXDATA) && dmem_writeb[0];
    assign wr_status = sel && (offset == OFF_STATUS) && dmem_writeb[0];
    assign wr_div    = sel && (offset == OFF_DIV) && (dmem_writeb[1:0] != 2'b00);
    assign busy      = (state_q != ST_IDLE);
    assign tx        = tx_q;
    assign unused_bits = ^{dmem_addr[1:0], dmem_writeb[3:2], dmem_wdata[31:16], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (dmem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = overflow_q;
`ifdef UART_TX_PARITY_EN
        status[STAT_PCAP]  = 1'b1;
`endif
    end

    always_comb begin
        dmem_rdata = '0;
        if (sel && dmem_read) begin
            case (offset)
                OFF_STATUS: dmem_rdata = status;
                OFF_DIV:    dmem_rdata = {16'h0000, div_q};
                default:    dmem_rdata = '0;
            endcase
        end
    end

    always_comb begin
        div_d = div_q;
        if (wr_div) begin
            if (dmem_writeb[0]) div_d[7:0]  = dmem_wdata[7:0];
            if (dmem_writeb[1]) div_d[15:8] = dmem_wdata[15:8];
            div_d = div_fix(div_d);
        end
        overflow_d = overflow_q;
        if (wr_status && dmem_wdata[STAT_OVF]) overflow_d = 1'b0;
        if (wr_txdata && fifo_full && !pop)    overflow_d = 1'b1;
    end

    // Every bit period reloads from the live divisor, so DIV writes apply from the next bit.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = div_q - 16'd1;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    baud_d   = div_q - 16'd1;
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = div_q - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_q == '0) begin
                    baud_d  = div_q - 16'd1;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_q == '0) state_d = ST_IDLE;
                else              baud_d  = baud_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            div_q      <= DIV_DEFAULT;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            div_q      <= div_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

endmodule
